// File: rtl/cart_ascii_multi.sv
// ASCII8/ASCII16 cartridge mapper serving CARTS slots, each with its own bank
// registers, SRAM mapping and SRAM-dirty flag for the save engine.
module cart_ascii_multi #(
    parameter int CARTS  = 2,
    parameter int ADDR_W = 25,
    parameter int CN_W   = (CARTS > 1) ? $clog2(CARTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    rom_size,
    input  logic [15:0]          size_sram,
    input  logic [CARTS-1:0]     mode16,
    input  logic [8*CARTS-1:0]   sram_sel_bit,
    input  logic [15:0]          cpu_addr,
    input  logic [7:0]           din,
    input  logic                 cpu_mreq,
    input  logic                 cpu_wr,
    input  logic                 cs,
    input  logic [CN_W-1:0]      cart_num,
    input  logic [CARTS-1:0]     save_ack,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_unmaped,
    output logic                 sram_cs,
    output logic                 sram_we,
    output logic [CARTS-1:0]     sram_dirty
);

    logic [7:0] bank    [CARTS][4];
    logic [7:0] sbank   [CARTS][4];
    logic [3:0] is_sram [CARTS];

    logic              sel_ok;
    logic [CN_W-1:0]   ci;
    logic              cs_eff;
    logic              m16;
    logic [7:0]        sel_mask;
    logic              wr_reg;
    logic              wr_ok;
    logic [1:0]        r;
    logic              to_sram;
    logic [15:0]       pages;
    logic [15:0]       pages_m1;
    logic [7:0]        smask;
    logic [1:0]        w;
    logic              win_sram;
    logic [7:0]        page;
    logic [21:0]       raw_addr;
    logic [ADDR_W+21:0] ext_addr;
    logic              in_range;

    always_comb begin
        // Out-of-range slot numbers behave as "not selected" and index slot 0 harmlessly.
        sel_ok   = (int'(cart_num) < CARTS);
        ci       = sel_ok ? cart_num : '0;
        cs_eff   = cs & sel_ok;
        m16      = mode16[ci];
        sel_mask = sram_sel_bit[int'(ci)*8 +: 8];

        wr_reg  = cs_eff & cpu_mreq & cpu_wr & (cpu_addr[15:13] == 3'b011);
        r       = cpu_addr[12:11];
        wr_ok   = wr_reg & (~m16 | ~r[0]);
        to_sram = (|(din & sel_mask)) && (size_sram != 16'd0);

        pages = m16 ? {4'b0, size_sram[15:4]} : {3'b0, size_sram[15:3]};
        if (pages == 16'd0)
            pages = 16'd1;
        pages_m1 = pages - 16'd1;
        smask    = pages_m1[7:0];

        w        = m16 ? {cpu_addr[15], 1'b0} : {cpu_addr[15], cpu_addr[13]};
        win_sram = is_sram[ci][w] & ~reset;
        page     = is_sram[ci][w] ? sbank[ci][w] : bank[ci][w];
        raw_addr = m16 ? {page, cpu_addr[13:0]} : {1'b0, page, cpu_addr[12:0]};
        ext_addr = {{ADDR_W{1'b0}}, raw_addr};
        mem_addr = reset ? '0 : ext_addr[ADDR_W-1:0];

        in_range    = cpu_addr[15] ^ cpu_addr[14];
        sram_cs     = cs_eff & in_range & win_sram;
        // SRAM in the 4000-7FFF window is read-only; 6000-7FFF writes are bank writes.
        sram_we     = sram_cs & cpu_mreq & cpu_wr & cpu_addr[15];
        mem_unmaped = cs_eff & (~in_range | (~win_sram & (mem_addr >= rom_size)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CARTS; c++) begin
                is_sram[c] <= 4'b0;
                for (int i = 0; i < 4; i++) begin
                    bank[c][i]  <= 8'h00;
                    sbank[c][i] <= 8'h00;
                end
            end
            sram_dirty <= '0;
        end else begin
            if (wr_ok) begin
                if (to_sram) begin
                    is_sram[ci][r] <= 1'b1;
                    sbank[ci][r]   <= din & smask;
                end else begin
                    is_sram[ci][r] <= 1'b0;
                    bank[ci][r]    <= din;
                end
            end
            // A new SRAM write in the ack cycle keeps the slot dirty.
            for (int c = 0; c < CARTS; c++) begin
                if (sram_we && (int'(ci) == c))
                    sram_dirty[c] <= 1'b1;
                else if (save_ack[c])
                    sram_dirty[c] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cart_ascii_multi.sv
// Bench for cart_ascii_multi: two slots (slot 0 ASCII8, slot 1 ASCII16), expected
// values queued as stimulus is applied and popped when outputs are sampled.
module tb_cart_ascii_multi;

    localparam int CARTS  = 2;
    localparam int ADDR_W = 25;
    localparam int CN_W   = 1;

    logic                clk;
    logic                reset;
    logic [ADDR_W-1:0]   rom_size;
    logic [15:0]         size_sram;
    logic [CARTS-1:0]    mode16;
    logic [8*CARTS-1:0]  sram_sel_bit;
    logic [15:0]         cpu_addr;
    logic [7:0]          din;
    logic                cpu_mreq;
    logic                cpu_wr;
    logic                cs;
    logic [CN_W-1:0]     cart_num;
    logic [CARTS-1:0]    save_ack;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_unmaped;
    logic                sram_cs;
    logic                sram_we;
    logic [CARTS-1:0]    sram_dirty;

    logic [31:0] exp_q[$];
    logic [31:0] exp;
    int passed;
    int total;

    cart_ascii_multi #(.CARTS(CARTS), .ADDR_W(ADDR_W), .CN_W(CN_W)) dut (
        .clk(clk), .reset(reset), .rom_size(rom_size), .size_sram(size_sram),
        .mode16(mode16), .sram_sel_bit(sram_sel_bit), .cpu_addr(cpu_addr),
        .din(din), .cpu_mreq(cpu_mreq), .cpu_wr(cpu_wr), .cs(cs),
        .cart_num(cart_num), .save_ack(save_ack), .mem_addr(mem_addr),
        .mem_unmaped(mem_unmaped), .sram_cs(sram_cs), .sram_we(sram_we),
        .sram_dirty(sram_dirty)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b1; cpu_addr = a; din = d;
        @(posedge clk);
        #1;
        cpu_mreq = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a);
        @(negedge clk);
        cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b0; cpu_addr = a;
        #1;
    endtask

    task automatic test_reset();
        cs = 1'b1; cpu_addr = 16'h4123; rom_size = 25'h0100000;
        #3;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); total++;
        if (32'(mem_addr) !== exp) $display("FAIL rst_mem_addr got %h exp %h", mem_addr, exp); else passed++;
        exp = exp_q.pop_front(); total++;
        if (32'(sram_dirty) !== exp) $display("FAIL rst_dirty got %h exp %h", sram_dirty, exp); else passed++;
        exp = exp_q.pop_front(); total++;
        if (32'(mem_unmaped) !== exp) $display("FAIL rst_unmaped_in got %h exp %h", mem_unmaped, exp); else passed++;
        cpu_addr = 16'h0000;
        exp_q.push_back(32'h1);
        #1;
        exp = exp_q.pop_front(); total++;
        if (32'(mem_unmaped) !== exp) $display("FAIL rst_unmaped_out got %h exp %h", mem_unmaped, exp); else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_ascii8();
        cart_num = 1'b0;
        cpu_write(16'h6800, 8'h05);
        cpu_read(16'h6123);
        exp_q.push_back(32'h0A123); exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); total++;
        if (32'(mem_addr) !== exp) $display("FAIL a8_read6123 got %h exp %h", mem_addr, exp); else passed++;
        exp = exp_q.pop_front(); total++;
        if (32'(sram_cs) !== exp) $display("FAIL a8_sram_cs got %h exp %h", sram_cs, exp); else passed++;
        cpu_read(16'h4000);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); total++;
        if (32'(mem_addr) !== exp) $display("FAIL a8_read4000 got %h exp %h", mem_addr, exp); else passed++;
        exp = exp_q.pop_front(); total++;
        if (32'(mem_unmaped) !== exp) $display("FAIL a8_unmaped4000 got %h exp %h", mem_unmaped, exp); else passed++;
    endtask

    task automatic test_ascii16();
        cart_num = 1'b1;
        cpu_write(16'h7000, 8'h03);
        cpu_read(16'h9ABC);
        exp_q.push_back(32'h0DABC);
        exp = exp_q.pop_front(); total++;
        if (32'(mem_addr) !== exp) $display("FAIL a16_read9abc got %h exp %h", mem_addr, exp); else passed++;
        cpu_write(16'h6800, 8'h07);
        cpu_read(16'h9ABC);
        exp_q.push_back(32'h0DABC);
        exp = exp_q.pop_front(); total++;
        if (32'(mem_addr) !== exp) $display("FAIL a16_ignored_w1 got %h exp %h", mem_addr, exp); else passed++;
        cpu_read(16'h5555);
        exp_q.push_back(32'h01555);
        exp = exp_q.pop_front(); total++;
        if (32'(mem_addr) !== exp) $display("FAIL a16_ignored_w0 got %h exp %h", mem_addr, exp); else passed++;
        cart_num = 1'b0;
        cpu_read(16'h6123);
        exp_q.push_back(32'h0A123);
        exp = exp_q.pop_front(); total++;
        if (32'(mem_addr) !== exp) $display("FAIL slot0_untouched got %h exp %h", mem_addr, exp); else passed++;
    endtask

    task automatic test_sram();
        cart_num = 1'b0; size_sram = 16'd8; sram_sel_bit = 16'h0010;
        cpu_write(16'h6000, 8'h10);
        @(negedge clk);
        cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h4010;
        #1;
        exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h10);
        exp = exp_q.pop_front(); total++;
        if (32'(sram_cs) !== exp) $display("FAIL ro_sram_cs got %h exp %h", sram_cs, exp); else passed++;
        exp = exp_q.pop_front(); total++;
        if (32'(sram_we) !== exp) $display("FAIL ro_sram_we got %h exp %h", sram_we, exp); else passed++;
        exp = exp_q.pop_front(); total++;
        if (32'(mem_addr) !== exp) $display("FAIL ro_mem_addr got %h exp %h", mem_addr, exp); else passed++;
        @(posedge clk);
        #1;
        cpu_mreq = 1'b0; cpu_wr = 1'b0;
        cpu_write(16'h7000, 8'h13);
        @(negedge clk);
        cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h8004;
        #1;
        exp_q.push_back(32'h1); exp_q.push_back(32'h4); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); total++;
        if (32'(sram_we) !== exp) $display("FAIL sram_we got %h exp %h", sram_we, exp); else passed++;
        exp = exp_q.pop_front(); total++;
        if (32'(mem_addr) !== exp) $display("FAIL sram_addr got %h exp %h", mem_addr, exp); else passed++;
        exp = exp_q.pop_front(); total++;
        if (32'(mem_unmaped) !== exp) $display("FAIL sram_unmaped got %h exp %h", mem_unmaped, exp); else passed++;
        exp = exp_q.pop_front(); total++;
        if (32'(sram_dirty) !== exp) $display("FAIL dirty_before got %h exp %h", sram_dirty, exp); else passed++;
        @(posedge clk);
        #1;
        cpu_mreq = 1'b0; cpu_wr = 1'b0;
        exp_q.push_back(32'h1);
        exp = exp_q.pop_front(); total++;
        if (32'(sram_dirty) !== exp) $display("FAIL dirty_rise got %h exp %h", sram_dirty, exp); else passed++;
    endtask

    task automatic test_dirty();
        @(negedge clk);
        cs = 1'b0; save_ack = 2'b01;
        @(posedge clk);
        #1;
        save_ack = 2'b00;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); total++;
        if (32'(sram_dirty) !== exp) $display("FAIL dirty_ack_clear got %h exp %h", sram_dirty, exp); else passed++;
        @(negedge clk);
        cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h8004; save_ack = 2'b01;
        @(posedge clk);
        #1;
        cpu_mreq = 1'b0; cpu_wr = 1'b0; save_ack = 2'b00;
        exp_q.push_back(32'h1);
        exp = exp_q.pop_front(); total++;
        if (32'(sram_dirty) !== exp) $display("FAIL dirty_set_wins got %h exp %h", sram_dirty, exp); else passed++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h8004;
        #1;
        exp_q.push_back(32'h1);
        exp = exp_q.pop_front(); total++;
        if (32'(sram_we) !== exp) $display("FAIL mid_we_before got %h exp %h", sram_we, exp); else passed++;
        reset = 1'b1;
        #1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); total++;
        if (32'(sram_we) !== exp) $display("FAIL mid_we got %h exp %h", sram_we, exp); else passed++;
        exp = exp_q.pop_front(); total++;
        if (32'(sram_cs) !== exp) $display("FAIL mid_cs got %h exp %h", sram_cs, exp); else passed++;
        exp = exp_q.pop_front(); total++;
        if (32'(mem_addr) !== exp) $display("FAIL mid_addr got %h exp %h", mem_addr, exp); else passed++;
        exp = exp_q.pop_front(); total++;
        if (32'(sram_dirty) !== exp) $display("FAIL mid_dirty got %h exp %h", sram_dirty, exp); else passed++;
        @(negedge clk);
        reset = 1'b0; cpu_mreq = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic test_unmapped();
        cart_num = 1'b0; rom_size = 25'h0008000;
        cpu_write(16'h6000, 8'h04);
        cpu_read(16'h4000);
        exp_q.push_back(32'h8000); exp_q.push_back(32'h1);
        exp = exp_q.pop_front(); total++;
        if (32'(mem_addr) !== exp) $display("FAIL um_addr got %h exp %h", mem_addr, exp); else passed++;
        exp = exp_q.pop_front(); total++;
        if (32'(mem_unmaped) !== exp) $display("FAIL um_bank4 got %h exp %h", mem_unmaped, exp); else passed++;
        cpu_write(16'h6000, 8'h03);
        cpu_read(16'h5FFF);
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); total++;
        if (32'(mem_unmaped) !== exp) $display("FAIL um_bank3 got %h exp %h", mem_unmaped, exp); else passed++;
        cpu_read(16'h0000);
        exp_q.push_back(32'h1);
        exp = exp_q.pop_front(); total++;
        if (32'(mem_unmaped) !== exp) $display("FAIL um_0000 got %h exp %h", mem_unmaped, exp); else passed++;
        cpu_read(16'hC000);
        exp_q.push_back(32'h1);
        exp = exp_q.pop_front(); total++;
        if (32'(mem_unmaped) !== exp) $display("FAIL um_c000 got %h exp %h", mem_unmaped, exp); else passed++;
        cs = 1'b0;
        #1;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); total++;
        if (32'(mem_unmaped) !== exp) $display("FAIL um_nocs got %h exp %h", mem_unmaped, exp); else passed++;
    endtask

    initial begin
        passed = 0; total = 0;
        reset = 1'b1; rom_size = '0; size_sram = 16'd0; mode16 = 2'b10;
        sram_sel_bit = 16'h0000; cpu_addr = 16'h0000; din = 8'h00;
        cpu_mreq = 1'b0; cpu_wr = 1'b0; cs = 1'b0; cart_num = 1'b0; save_ack = 2'b00;
        test_reset();
        test_ascii8();
        test_ascii16();
        test_sram();
        test_dirty();
        test_reset_mid();
        test_unmapped();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cart_ascii_multi.md
# cart_ascii_multi

Parametrised ASCII-family cartridge mapper: one instance serves CARTS cartridge slots. Each slot runs in ASCII8 (four 8 KB windows) or ASCII16 (two 16 KB windows) mode and has its own bank, SRAM-mapping and SRAM-dirty state. It sits between the slot decoder (cs, cart_num) and the cartridge memory arbiter (mem_addr, sram_cs/sram_we). The dirty handshake tells the save engine which slot's battery RAM needs flushing to SD.

## Interface
- CARTS, 2: number of cartridge slots served; ≥1.
- ADDR_W, 25: memory address width.
- CN_W, max(1,$clog2(CARTS)): width of cart_num.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rom_size  in  ADDR_W  ROM byte count of the selected slot.
- size_sram  in  16  SRAM size of the selected slot, in KB; 0 = no SRAM.
- mode16  in  CARTS  per-slot mode: 1 = ASCII16, 0 = ASCII8; static while the slot is in use.
- sram_sel_bit  in  8*CARTS  per-slot mask; slot c uses bits [8c+7:8c]. Any masked bit set in a bank write selects SRAM.
- cpu_addr  in  16  CPU address.
- din  in  8  CPU write data.
- cpu_mreq  in  1  memory request.
- cpu_wr  in  1  write.
- cs  in  1  slot selected.
- cart_num  in  CN_W  slot index; values ≥ CARTS are treated as not selected.
- save_ack  in  CARTS  per-slot one-cycle pulse: save engine has captured the SRAM.
- mem_addr  out  ADDR_W  translated ROM/SRAM address.
- mem_unmaped  out  1  access hits no memory.
- sram_cs  out  1  current access targets SRAM.
- sram_we  out  1  SRAM write strobe.
- sram_dirty  out  CARTS  per-slot flag: SRAM written since the last ack.

## Operation
- Per-slot state: bank[c][4] (8 bit), is_sram[c][4], sbank[c][4] (8 bit), sram_dirty[c].
- Register write condition: wr_reg = cs & cpu_mreq & cpu_wr & cpu_addr[15:13]==3'b011. Index r = cpu_addr[12:11].
- ASCII8: r selects window 4000/6000/8000/A000.
- ASCII16: r=0 selects window 0 (4000–7FFF); r=2 selects window 1 (8000–BFFF). Writes with r=1 or r=3 are ignored.
- SRAM selection on a register write:
  - If (din & sram_sel_bit[c]) != 0 and size_sram != 0, then is_sram[r]=1 and sbank[r] = din & smask.
  - Otherwise is_sram[r]=0 and bank[r]=din.
- smask = pages−1, where pages = size_sram/8 (ASCII8) or size_sram/16 (ASCII16), clamped to a minimum of 1, truncated to 8 bits.
- Window index w for reads:
  - ASCII8: w = {cpu_addr[15], cpu_addr[13]}.
  - ASCII16: w = {cpu_addr[15], 1'b0}, i.e. r-slot 0 or 2.
- Offset: cpu_addr[12:0] in ASCII8, cpu_addr[13:0] in ASCII16.
- mem_addr = {is_sram[w] ? sbank[w] : bank[w], offset}, zero-extended or truncated to ADDR_W.
- sram_cs = cs & in_range & is_sram[w], where in_range = cpu_addr[15:14] ∈ {01, 10}.
- sram_we = sram_cs & cpu_mreq & cpu_wr & cpu_addr[15]. Only 8000–BFFF is writable; SRAM mapped at 4000–7FFF is read-only.
- A CPU write into SRAM at 6000–7FFF is a bank-register write, never an SRAM write.
- mem_unmaped = cs & (~in_range | (~is_sram[w] & mem_addr ≥ rom_size)).
- Dirty flag:
  - sram_dirty[cart_num] is set on any cycle with sram_we.
  - It is cleared by save_ack[c].
  - If set and clear coincide, set wins.
- Slots are fully independent; state of unselected slots never changes.

## Timing
- Reset (async assert): all bank, sbank, is_sram and sram_dirty registers clear to 0.
- Output values during reset:
  - mem_addr = 0.
  - sram_cs = 0, sram_we = 0.
  - mem_unmaped = cs & (~in_range | rom_size==0).
- Bank/SRAM register update lands on the clk edge where wr_reg is high. Translation uses the new value from the next cycle.
- mem_addr, sram_cs, sram_we and mem_unmaped are combinational from registers and current inputs, with zero latency.
- A wr_reg held for several cycles rewrites the same value, so it is idempotent.
- sram_dirty rises on the edge after the first sram_we cycle. It falls on the edge after save_ack unless a new sram_we occurs in that same cycle.
- A mode16 change while the slot is active is unsupported; register contents are kept, not cleared.

## Test plan
- Reset, ASCII8 slot 0, write 6800←05, read 6123 → mem_addr 0x0A123, sram_cs 0. Also read 4000 → mem_addr 0, mem_unmaped 0.
- ASCII16 slot 1, write 7000←03, read 9ABC → mem_addr 0x0D ABC (3·16K+1ABC = 0x0DABC). A write 6800←07 leaves both windows unchanged.
- ASCII8, size_sram=8, sram_sel_bit=0x10:
  - Write 7000←13 → window 8000 maps to SRAM, sbank 0.
  - Write at 8004 → sram_we 1, mem_addr 0x00004.
  - sram_dirty[0] rises one cycle later.
- Dirty handshake: save_ack[0] pulse with no write → flag clears. save_ack[0] in the same cycle as sram_we → flag stays 1.
- rom_size=0x8000, bank 4 at 4000 → mem_unmaped 1. Read 0000 or C000 with cs → mem_unmaped 1. With cs=0 → 0.
- Assert reset mid-access after mapping SRAM → all outputs and dirty flags return to 0 immediately, without a clock edge.
